// File: rtl/gpio_host_sequencer.sv
// Host-side GPIO sequencer for mips_top self-test.
// Sweeps gpi_1 over 0..N_VECTORS-1 and captures gpo_1/gpo_2 per pass.
module gpio_host_sequencer #(
    parameter int          N_VECTORS  = 16,
    parameter logic [31:0] DONE_PC    = 32'h0000_00C8,
    parameter logic [31:0] GPI2_VALUE = 32'h0000_0000,
    parameter int          TIMEOUT    = 1024,
    parameter int          IDX_W      = $clog2(N_VECTORS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [31:0]      pc_current,
    input  logic [31:0]      gpo_1,
    input  logic [31:0]      gpo_2,
    output logic [31:0]      gpi_1,
    output logic [31:0]      gpi_2,
    output logic             busy,
    output logic             res_valid,
    output logic [IDX_W-1:0] res_index,
    output logic [31:0]      res_data_1,
    output logic [31:0]      res_data_2,
    output logic             done,
    output logic             timeout_err
);

    localparam int TCNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_HOLD,
        S_CAPTURE,
        S_DONE,
        S_ERROR
    } state_t;

    state_t              state;
    logic [IDX_W-1:0]    idx;
    logic [TCNT_W-1:0]   tcnt;
    logic                armed;

    wire at_done_pc = (pc_current == DONE_PC);
    wire last_idx   = (idx == IDX_W'(N_VECTORS - 1));
    wire tcnt_max   = (tcnt == TCNT_W'(TIMEOUT - 1));

    // Sequencer FSM; every output is a register updated here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            idx         <= '0;
            tcnt        <= '0;
            armed       <= 1'b0;
            gpi_1       <= '0;
            gpi_2       <= '0;
            busy        <= 1'b0;
            res_valid   <= 1'b0;
            res_index   <= '0;
            res_data_1  <= '0;
            res_data_2  <= '0;
            done        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            res_valid <= 1'b0;
            unique case (state)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (start) begin
                        idx         <= '0;
                        gpi_1       <= '0;
                        gpi_2       <= GPI2_VALUE;
                        busy        <= 1'b1;
                        done        <= 1'b0;
                        timeout_err <= 1'b0;
                        tcnt        <= '0;
                        armed       <= 1'b0;
                        state       <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    tcnt <= tcnt + TCNT_W'(1);
                    // A PC parked on DONE_PC at entry must leave first.
                    if (!at_done_pc) begin
                        armed <= 1'b1;
                    end
                    if (armed && at_done_pc) begin
                        state <= S_HOLD;
                    end else if (tcnt_max) begin
                        state       <= S_ERROR;
                        timeout_err <= 1'b1;
                        busy        <= 1'b0;
                    end
                end
                // One spare cycle so the pass's final store lands.
                S_HOLD: begin
                    state <= S_CAPTURE;
                end
                S_CAPTURE: begin
                    res_valid  <= 1'b1;
                    res_index  <= idx;
                    res_data_1 <= gpo_1;
                    res_data_2 <= gpo_2;
                    if (last_idx) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        idx   <= idx + IDX_W'(1);
                        gpi_1 <= 32'(idx) + 32'd1;
                        tcnt  <= '0;
                        armed <= 1'b0;
                        state <= S_WAIT;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/gpio_host_sequencer.md
Name: gpio_host_sequencer

Overview:
- Host-side driver for the SoC general-purpose I/O interface; it drives `gpi_1`/`gpi_2` into `mips_top`.
- It steps `gpi_1` through the operand sweep 0..N_VECTORS-1.
- For each operand it waits until the core's program reaches its completion address, holds one extra cycle, then captures `gpo_1`/`gpo_2` as the result.
- Used in on-board self-test builds to exercise the core without an external host; results stream out one per vector.

Parameters:
- N_VECTORS, 16: number of operands swept on `gpi_1` (values 0..N_VECTORS-1); must be ≥2.
- DONE_PC, 32'h000000C8: `pc_current` value marking end of one program pass.
- GPI2_VALUE, 32'h00000000: constant driven on `gpi_2` while busy.
- TIMEOUT, 1024: maximum cycles allowed per vector before abort.
- IDX_W, $clog2(N_VECTORS): width of `res_index`.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  begin sweep; sampled only in IDLE, DONE or ERROR
- pc_current  in  32  core program counter
- gpo_1  in  32  core output port 1
- gpo_2  in  32  core output port 2
- gpi_1  out  32  operand to core
- gpi_2  out  32  auxiliary input to core
- busy  out  1  sweep in progress
- res_valid  out  1  one-cycle pulse: result captured
- res_index  out  IDX_W  operand index of captured result
- res_data_1  out  32  captured `gpo_1`
- res_data_2  out  32  captured `gpo_2`
- done  out  1  sticky: all vectors captured
- timeout_err  out  1  sticky: a vector exceeded TIMEOUT

Behaviour:
- Reset (sync, `rst`=1 at posedge):
  - State → IDLE.
  - All outputs 0; `gpi_2` = 0.
  - Index, timeout counter and `armed` flag cleared.
  - `rst` asserted in any state aborts the sweep the same edge.
- All outputs are registered.
- States: IDLE, WAIT, HOLD, CAPTURE, DONE, ERROR.
- IDLE / DONE / ERROR with `start`=1:
  - idx ← 0, `gpi_1` ← 0, `gpi_2` ← GPI2_VALUE.
  - `busy` ← 1; `done` ← 0; `timeout_err` ← 0.
  - tcnt ← 0, `armed` ← 0, → WAIT.
- `start` while `busy`=1 is ignored.
- WAIT:
  - tcnt increments every cycle.
  - `armed` ← 1 on any cycle with `pc_current` != DONE_PC.
  - If `armed`=1 and `pc_current` == DONE_PC → HOLD. A PC already sitting at DONE_PC when WAIT is entered does not count; it must leave and return.
  - Else if tcnt == TIMEOUT-1 → ERROR.
- HOLD: exactly one cycle (lets the final store of the pass land) → CAPTURE.
- CAPTURE (one cycle):
  - `res_valid` asserts the cycle after, with `res_data_1` = `gpo_1`, `res_data_2` = `gpo_2` sampled in CAPTURE, and `res_index` = idx.
  - If idx == N_VECTORS-1 → DONE, `busy` ← 0, `done` ← 1.
  - Else idx ← idx+1, `gpi_1` ← idx+1 zero-extended, tcnt ← 0, `armed` ← 0, → WAIT.
- Latency: `res_valid` rises 3 cycles after the first edge where `pc_current` == DONE_PC (armed).
- ERROR:
  - `timeout_err` ← 1, `busy` ← 0.
  - `gpi_1` holds the failing operand.
  - `res_valid` is not pulsed for the failed vector.
- `gpi_1` changes only on start and in CAPTURE; otherwise it is stable.
- `res_data_*`/`res_index` hold their last value between pulses.
- DONE and ERROR are sticky until the next `start` or `rst`.

Test Plan:
- Nominal sweep. Core model returns `gpo_1` = 3×`gpi_1` and hits pc 0xC8 every 20 cycles; pulse `start` → 16 `res_valid` pulses, `res_index` 0..15, `res_data_1` 0,3,…,45; then `done`=1, `busy`=0.
- Pre-armed PC. `pc_current` held at 0xC8 when `start` is pulsed, leaves after 5 cycles, returns at cycle 12 → capture occurs only after the return; `res_valid` at cycle 15 from the armed hit.
- Timeout. Set TIMEOUT=64 and let the PC never reach 0xC8 on vector 3 → vectors 0–2 captured; `timeout_err`=1 at cycle 64 of vector 3; `gpi_1`=3; no 4th pulse.
- Reset mid-sweep. Assert `rst` for 1 cycle during vector 7 WAIT → next cycle all outputs 0, IDLE; a new `start` restarts at `gpi_1`=0.
- Start ignored / restart. Pulse `start` during vector 2 → sweep unaffected. Pulse `start` in DONE → `done` clears, `gpi_2`=GPI2_VALUE, sweep reruns identically.
